// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store sequencer: RISC-V load/store
// funct3 encodings, the controller state encoding and an access-size helper.
package lsu_ctrl_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_READ  = 2'd1,
        LSU_WRITE = 2'd2,
        LSU_RESP  = 2'd3
    } lsu_state_t;

    // Access size in bytes (1, 2, 4 or 8) from funct3[1:0].
    function automatic logic [3:0] access_size(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

endpackage

// File: rtl/lsu_chk.sv
// Request legality check, purely combinational.
//   we, funct3, off : request direction, funct3 and low address bits
//   misalign        : address not a multiple of the access size
//   illegal         : funct3 not valid for this direction / XLEN
//   full_width      : access covers the whole bus word
module lsu_chk import lsu_ctrl_pkg::*; #(
    parameter int XLEN = 32,
    localparam int AW = $clog2(XLEN / 8)
) (
    input  logic          we,
    input  logic [2:0]    funct3,
    input  logic [AW-1:0] off,
    output logic          misalign,
    output logic          illegal,
    output logic          full_width
);
    logic [3:0] size;

    always_comb begin
        size       = access_size(funct3);
        misalign   = |((size - 4'd1) & 4'(off));
        illegal    = ((funct3[1:0] == F3_LD[1:0]) && (XLEN == 32)) ||
                     (!we && (funct3 == 3'b111)) ||
                     (we && funct3[2]);
        full_width = (size == 4'(XLEN / 8));
    end
endmodule

// File: rtl/lu.sv
// Load unit: extracts the addressed byte/half/word from a bus word and
// sign- or zero-extends it according to funct3.
//   off, funct3 : byte offset within the word and load type
//   data        : full bus word;  result : extended load value
module lu import lsu_ctrl_pkg::*; #(
    parameter int XLEN = 32,
    localparam int AW = $clog2(XLEN / 8)
) (
    input  logic [AW-1:0]   off,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] result
);
    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = data >> {off, 3'b000};
        case (funct3)
            F3_LB:   result = XLEN'($signed(shifted[7:0]));
            F3_LH:   result = XLEN'($signed(shifted[15:0]));
            F3_LW:   result = XLEN'($signed(shifted[31:0]));
            F3_LD:   result = shifted;
            F3_LBU:  result = XLEN'(shifted[7:0]);
            F3_LHU:  result = XLEN'(shifted[15:0]);
            F3_LWU:  result = XLEN'(shifted[31:0]);
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/su.sv
// Store unit: merges right-aligned store data into an existing bus word at
// the addressed byte lanes.
//   off, funct3 : byte offset and store type
//   old, wdata  : previous bus word and store data;  merged : new bus word
module su import lsu_ctrl_pkg::*; #(
    parameter int XLEN = 32,
    localparam int AW = $clog2(XLEN / 8)
) (
    input  logic [AW-1:0]   off,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] merged
);
    logic [XLEN-1:0] lanes;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] shifted;

    always_comb begin
        case (funct3)
            F3_SB:   lanes = XLEN'(8'hFF);
            F3_SH:   lanes = XLEN'(16'hFFFF);
            F3_SW:   lanes = XLEN'(32'hFFFF_FFFF);
            F3_SD:   lanes = '1;
            default: lanes = '0;
        endcase
        mask    = lanes << {off, 3'b000};
        shifted = wdata << {off, 3'b000};
        merged  = (old & ~mask) | (shifted & mask);
    end
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between execute and the data-memory bus. Accepts one
// request at a time, issues aligned full-width bus transactions (sub-word
// stores as read-modify-write) and returns a one-cycle completion pulse.
//   clk, rst_n                         : clock, async active-low reset
//   req_valid/ready/we/funct3/addr/wdata : request from the pipeline
//   rsp_valid/err/rdata                : completion pulse, error, load data
//   mem_req/we/addr/wdata, mem_ack/rdata : data-memory bus
module lsu_ctrl import lsu_ctrl_pkg::*; #(
    parameter int XLEN = 32,
    localparam int AW = $clog2(XLEN / 8)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic            rsp_err,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);
    lsu_state_t      state_q, state_d;
    logic [AW-1:0]   off_q;
    logic [2:0]      funct3_q;
    logic            we_q, err_q;
    logic [XLEN-1:0] wdata_q, rd_q, mem_addr_q, mem_wdata_q;
    logic            misalign, illegal, full_width, accept;
    logic [XLEN-1:0] load_data, merged;

    lsu_chk #(.XLEN(XLEN)) u_chk (
        .we(req_we), .funct3(req_funct3), .off(req_addr[AW-1:0]),
        .misalign(misalign), .illegal(illegal), .full_width(full_width)
    );

    lu #(.XLEN(XLEN)) u_lu (
        .off(off_q), .funct3(funct3_q), .data(rd_q), .result(load_data)
    );

    // Merging straight from the bus read data lets the write word be
    // registered in the same edge that captures rd_q, so mem_wdata is
    // already stable on the first WRITE cycle.
    su #(.XLEN(XLEN)) u_su (
        .off(off_q), .funct3(funct3_q), .old(mem_rdata), .wdata(wdata_q),
        .merged(merged)
    );

    assign accept    = req_valid && (state_q == LSU_IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= LSU_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (misalign || illegal)      state_d = LSU_RESP;
                    else if (req_we && full_width) state_d = LSU_WRITE;
                    else                          state_d = LSU_READ;
                end
            end
            LSU_READ: begin
                mem_req = 1'b1;
                if (mem_ack) state_d = we_q ? LSU_WRITE : LSU_RESP;
            end
            LSU_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) state_d = LSU_RESP;
            end
            LSU_RESP: begin
                rsp_valid = 1'b1;
                state_d   = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = (rsp_valid && !we_q && !err_q) ? load_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q       <= '0;
            funct3_q    <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            wdata_q     <= '0;
            rd_q        <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if (accept) begin
                off_q       <= req_addr[AW-1:0];
                funct3_q    <= req_funct3;
                we_q        <= req_we;
                err_q       <= misalign || illegal;
                wdata_q     <= req_wdata;
                mem_addr_q  <= {req_addr[XLEN-1:AW], {AW{1'b0}}};
                // Full-width stores write this directly; sub-word stores
                // replace it with the merged word after the read.
                mem_wdata_q <= req_wdata;
            end
            if ((state_q == LSU_READ) && mem_ack) begin
                rd_q <= mem_rdata;
                if (we_q) mem_wdata_q <= merged;
            end
        end
    end
endmodule
